vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/pixel_tick_gen.sv | 30 +++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the Whack-A-Mole display path.
// Holds the 640x480@60 defaults plus a tiny timing set used for fast simulation.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_CLK_DIV  = 4;

    // Miniature frame (14 x 8 pixel periods) so a whole frame fits in a few hundred clocks.
    localparam int SIM_H_ACTIVE = 8;
    localparam int SIM_H_FRONT  = 2;
    localparam int SIM_H_SYNC   = 3;
    localparam int SIM_H_BACK   = 1;
    localparam int SIM_V_ACTIVE = 4;
    localparam int SIM_V_FRONT  = 1;
    localparam int SIM_V_SYNC   = 2;
    localparam int SIM_V_BACK   = 1;
    localparam int SIM_CLK_DIV  = 2;

    function automatic int timing_total(input int active, input int front,
                                        input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel clock-enable: one-clock pulse every CLK_DIV system clocks, restarted by reset.
module pixel_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = count_width(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          div_last;

    assign div_last = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || div_last) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Masked during reset so a CLK_DIV of 1 cannot advance anything while reset is held.
    assign tick = !rst && div_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and registered pixel-output stage: counters, syncs,
// renderer coordinates, and colour/sync pins aligned one pixel period later.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FRONT  = VGA_H_FRONT,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BACK   = VGA_H_BACK,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FRONT  = VGA_V_FRONT,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BACK   = VGA_V_BACK,
    parameter int   CLK_DIV  = VGA_CLK_DIV,
    parameter logic SYNC_POL = 1'b0,
    parameter int   R_W      = 3,
    parameter int   G_W      = 3,
    parameter int   B_W      = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [R_W-1:0]                     rgb_r,
    input  logic [G_W-1:0]                     rgb_g,
    input  logic [B_W-1:0]                     rgb_b,
    output logic [count_width(H_ACTIVE)-1:0]   pixel_x,
    output logic [count_width(V_ACTIVE)-1:0]   pixel_y,
    output logic                               pixel_req,
    output logic                               pix_tick,
    output logic                               line_start,
    output logic                               frame_start,
    output logic [R_W-1:0]                     red_pin,
    output logic [G_W-1:0]                     green_pin,
    output logic [B_W-1:0]                     blue_pin,
    output logic                               horizontal_sync,
    output logic                               vertical_sync
);

    localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW       = count_width(H_TOTAL);
    localparam int VW       = count_width(V_TOTAL);
    localparam int XW       = count_width(H_ACTIVE);
    localparam int YW       = count_width(V_ACTIVE);
    localparam int HS_FIRST = H_ACTIVE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_raw;
    logic          vs_raw;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (pix_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                if (v_cnt == VW'(V_TOTAL - 1)) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Stage 0: everything the renderer sees is decoded straight from the counters.
    always_comb begin
        pixel_req = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        pixel_x   = pixel_req ? h_cnt[XW-1:0] : '0;
        pixel_y   = pixel_req ? v_cnt[YW-1:0] : '0;
        hs_raw    = (h_cnt >= HW'(HS_FIRST)) && (h_cnt <= HW'(HS_LAST));
        vs_raw    = (v_cnt >= VW'(VS_FIRST)) && (v_cnt <= VW'(VS_LAST));
    end

    assign line_start  = pix_tick && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

    // Stage 1: syncs share the colour register so both leave on the same pixel period.
    always_ff @(posedge clk) begin
        if (rst) begin
            red_pin         <= '0;
            green_pin       <= '0;
            blue_pin        <= '0;
            horizontal_sync <= ~SYNC_POL;
            vertical_sync   <= ~SYNC_POL;
        end else if (pix_tick) begin
            red_pin         <= pixel_req ? rgb_r : '0;
            green_pin       <= pixel_req ? rgb_g : '0;
            blue_pin        <= pixel_req ? rgb_b : '0;
            horizontal_sync <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vertical_sync   <= vs_raw ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on the small timing set: one DUT with CLK_DIV=2 and
// active-low syncs, one with CLK_DIV=1 and active-high syncs, both against a frame-position model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HT       = SIM_H_ACTIVE + SIM_H_FRONT + SIM_H_SYNC + SIM_H_BACK;
    localparam int VT       = SIM_V_ACTIVE + SIM_V_FRONT + SIM_V_SYNC + SIM_V_BACK;
    localparam int FT       = HT * VT;
    localparam int HS_FIRST = SIM_H_ACTIVE + SIM_H_FRONT;
    localparam int HS_LAST  = HS_FIRST + SIM_H_SYNC - 1;
    localparam int VS_FIRST = SIM_V_ACTIVE + SIM_V_FRONT;
    localparam int VS_LAST  = VS_FIRST + SIM_V_SYNC - 1;

    typedef struct {
        int         tick_no;
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
        logic       hs;
    } line_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rgb_g = 3'd5;
    logic [1:0] rgb_b = 2'd2;

    logic [2:0] px  [2];
    logic [1:0] py  [2];
    logic       req [2];
    logic       tick[2];
    logic       ls  [2];
    logic       fs  [2];
    logic [2:0] red [2];
    logic [2:0] grn [2];
    logic [1:0] blu [2];
    logic       hs  [2];
    logic       vs  [2];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: clocks since the last reset edge, and pin values per DUT.
    int         m_k [2] = '{0, 0};
    logic [2:0] e_r [2];
    logic [2:0] e_g [2];
    logic [1:0] e_b [2];
    logic       e_hs[2];
    logic       e_vs[2];

    line_vec_t line_table[14];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (SIM_H_ACTIVE), .H_FRONT (SIM_H_FRONT), .H_SYNC (SIM_H_SYNC), .H_BACK (SIM_H_BACK),
        .V_ACTIVE (SIM_V_ACTIVE), .V_FRONT (SIM_V_FRONT), .V_SYNC (SIM_V_SYNC), .V_BACK (SIM_V_BACK),
        .CLK_DIV  (2), .SYNC_POL (1'b0), .R_W (3), .G_W (3), .B_W (2)
    ) dut_a (
        .clk (clk), .rst (rst), .rgb_r (px[0]), .rgb_g (rgb_g), .rgb_b (rgb_b),
        .pixel_x (px[0]), .pixel_y (py[0]), .pixel_req (req[0]), .pix_tick (tick[0]),
        .line_start (ls[0]), .frame_start (fs[0]), .red_pin (red[0]), .green_pin (grn[0]),
        .blue_pin (blu[0]), .horizontal_sync (hs[0]), .vertical_sync (vs[0])
    );

    vga_timing_gen #(
        .H_ACTIVE (SIM_H_ACTIVE), .H_FRONT (SIM_H_FRONT), .H_SYNC (SIM_H_SYNC), .H_BACK (SIM_H_BACK),
        .V_ACTIVE (SIM_V_ACTIVE), .V_FRONT (SIM_V_FRONT), .V_SYNC (SIM_V_SYNC), .V_BACK (SIM_V_BACK),
        .CLK_DIV  (1), .SYNC_POL (1'b1), .R_W (3), .G_W (3), .B_W (2)
    ) dut_b (
        .clk (clk), .rst (rst), .rgb_r (px[1]), .rgb_g (rgb_g), .rgb_b (rgb_b),
        .pixel_x (px[1]), .pixel_y (py[1]), .pixel_req (req[1]), .pix_tick (tick[1]),
        .line_start (ls[1]), .frame_start (fs[1]), .red_pin (red[1]), .green_pin (grn[1]),
        .blue_pin (blu[1]), .horizontal_sync (hs[1]), .vertical_sync (vs[1])
    );

    function automatic int div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic pol_of(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    // Frame position is just (completed ticks) mod frame length, split into h and v.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int  n, h, v;
            logic act;
            if (rst) begin
                m_k[d]  = 0;
                e_r[d]  = 3'd0;
                e_g[d]  = 3'd0;
                e_b[d]  = 2'd0;
                e_hs[d] = ~pol_of(d);
                e_vs[d] = ~pol_of(d);
            end else begin
                if ((m_k[d] % div_of(d)) == div_of(d) - 1) begin
                    n   = (m_k[d] / div_of(d)) % FT;
                    h   = n % HT;
                    v   = n / HT;
                    act = (h < SIM_H_ACTIVE) && (v < SIM_V_ACTIVE);
                    e_r[d]  = act ? 3'(h) : 3'd0;
                    e_g[d]  = act ? rgb_g : 3'd0;
                    e_b[d]  = act ? rgb_b : 2'd0;
                    e_hs[d] = (h >= HS_FIRST && h <= HS_LAST) ? pol_of(d) : ~pol_of(d);
                    e_vs[d] = (v >= VS_FIRST && v <= VS_LAST) ? pol_of(d) : ~pol_of(d);
                end
                m_k[d] = m_k[d] + 1;
            end
        end
    end

    function automatic logic [18:0] expectAll(input int d, input logic rst_now);
        int   n, h, v;
        logic act, tk;
        n   = (m_k[d] / div_of(d)) % FT;
        h   = n % HT;
        v   = n / HT;
        act = (h < SIM_H_ACTIVE) && (v < SIM_V_ACTIVE);
        tk  = !rst_now && ((m_k[d] % div_of(d)) == div_of(d) - 1);
        return {act ? 3'(h) : 3'd0, act ? 2'(v) : 2'd0, act, tk, tk && (h == 0), tk && (n == 0),
                e_r[d], e_g[d], e_b[d], e_hs[d], e_vs[d]};
    endfunction

    function automatic logic [18:0] actualAll(input int d);
        return {px[d], py[d], req[d], tick[d], ls[d], fs[d], red[d], grn[d], blu[d], hs[d], vs[d]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic [2:0] g, input logic [1:0] b);
        @(negedge clk);
        rst   = rst_val;
        rgb_g = g;
        rgb_b = b;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  fs_a, ls_a, req_a, hsl_a, vsl_a, tk_b, fs_b, ls_b, hsh_b, vsh_b;
        bit  found;

        line_table[0]  = '{1,  3'd0, 3'd5, 2'd2, 1'b1};
        line_table[1]  = '{2,  3'd1, 3'd5, 2'd2, 1'b1};
        line_table[2]  = '{3,  3'd2, 3'd5, 2'd2, 1'b1};
        line_table[3]  = '{4,  3'd3, 3'd5, 2'd2, 1'b1};
        line_table[4]  = '{5,  3'd4, 3'd5, 2'd2, 1'b1};
        line_table[5]  = '{6,  3'd5, 3'd5, 2'd2, 1'b1};
        line_table[6]  = '{7,  3'd6, 3'd5, 2'd2, 1'b1};
        line_table[7]  = '{8,  3'd7, 3'd5, 2'd2, 1'b1};
        line_table[8]  = '{9,  3'd0, 3'd0, 2'd0, 1'b1};
        line_table[9]  = '{10, 3'd0, 3'd0, 2'd0, 1'b1};
        line_table[10] = '{11, 3'd0, 3'd0, 2'd0, 1'b0};
        line_table[11] = '{12, 3'd0, 3'd0, 2'd0, 1'b0};
        line_table[12] = '{13, 3'd0, 3'd0, 2'd0, 1'b0};
        line_table[13] = '{14, 3'd0, 3'd0, 2'd0, 1'b1};

        // Reset held for five clocks: pins cleared, syncs idle, no ticks.
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_rgb_a", {red[0], grn[0], blu[0]}, 8'd0);
        checkOutput("reset_sync_a", {hs[0], vs[0]}, 2'b11);
        checkOutput("reset_sync_b", {hs[1], vs[1]}, 2'b00);
        checkOutput("reset_tick", {tick[0], tick[1], ls[0], fs[0], ls[1], fs[1]}, 6'd0);
        checkOutput("reset_coord_a", {req[0], px[0], py[0]}, {1'b1, 3'd0, 2'd0});

        rst = 1'b0;
        #1;
        checkOutput("first_clk_no_tick", tick[0], 1'b0);
        @(negedge clk);
        #1;
        checkOutput("second_clk_tick", {tick[0], ls[0], fs[0]}, 3'b111);

        // Line 0 on the divided DUT: colour follows pixel_x one tick late, syncs idle except h 10..12.
        for (int i = 0; i < 14; i++) begin
            repeat ((i == 0) ? 1 : 2) @(negedge clk);
            #1;
            checkOutput($sformatf("line0_tick%0d", line_table[i].tick_no),
                        {red[0], grn[0], blu[0], hs[0], vs[0]},
                        {line_table[i].red, line_table[i].green, line_table[i].blue,
                         line_table[i].hs, 1'b1});
        end

        // 448 clocks: two frames on the divided DUT, four on the undivided one.
        {fs_a, ls_a, req_a, hsl_a, vsl_a, tk_b, fs_b, ls_b, hsh_b, vsh_b} = '0;
        for (int c = 0; c < 448; c++) begin
            applyStimulus(1'b0, 3'd5, 2'd2);
            if (tick[0]) begin
                fs_a  += int'(fs[0]);
                ls_a  += int'(ls[0]);
                req_a += int'(req[0]);
                hsl_a += int'(!hs[0]);
                vsl_a += int'(!vs[0]);
            end
            if (tick[1]) begin
                tk_b  += 1;
                fs_b  += int'(fs[1]);
                ls_b  += int'(ls[1]);
                hsh_b += int'(hs[1]);
                vsh_b += int'(vs[1]);
            end
        end
        checkOutput("frames_a", fs_a, 2);
        checkOutput("lines_a", ls_a, 16);
        checkOutput("req_ticks_a", req_a, 64);
        checkOutput("hsync_low_ticks_a", hsl_a, 48);
        checkOutput("vsync_low_ticks_a", vsl_a, 56);
        checkOutput("ticks_b", tk_b, 448);
        checkOutput("frames_b", fs_b, 4);
        checkOutput("lines_b", ls_b, 32);
        checkOutput("hsync_high_ticks_b", hsh_b, 96);
        checkOutput("vsync_high_ticks_b", vsh_b, 112);

        // One-clock reset while the divided DUT sits at (5,2).
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (((m_k[0] / 2) % FT) == 2 * HT + 5) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_h5_v2", found, 1'b1);
        checkOutput("pre_reset_red_a", red[0], 3'd4);
        rst = 1'b1;
        #1;
        checkOutput("in_reset_pulses", {tick[0], ls[0], fs[0], tick[1], fs[1]}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_coord_a", {req[0], px[0], py[0]}, {1'b1, 3'd0, 2'd0});
        checkOutput("post_reset_pins_a", {red[0], grn[0], blu[0], hs[0], vs[0]}, {8'd0, 2'b11});
        checkOutput("post_reset_no_frame_a", {tick[0], fs[0]}, 2'b00);
        @(negedge clk);
        #1;
        checkOutput("post_reset_frame_a", {tick[0], fs[0]}, 2'b11);

        // Random colours and occasional resets, both DUTs against the model every clock.
        for (int c = 0; c < 2500; c++) begin
            applyStimulus(($urandom_range(0, 149) == 0), 3'($urandom), 2'($urandom));
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("random_dut%0d_clk%0d", d, c),
                            32'(actualAll(d)), 32'(expectAll(d, rst)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
